// File: rtl/output_sequencer.sv
// output_sequencer: output counterpart of the button input chain. Patterns are pushed into a
// first-word-fall-through FIFO. Each pattern is driven on `out` for HOLD_CNT_MAX cycles and is
// then followed by GAP_CNT_MAX cycles of zero, so that two identical consecutive events can
// still be told apart. Typical uses are LEDs and other user-visible events fed from MMIO or an
// event source.
//
// Build option:
//   OUTPUT_SEQUENCER_FLUSH_EN - adds a synchronous, active-high `flush` input. When flush is
//                               high it empties the FIFO, aborts the current event and discards
//                               any write on the same edge.
//
// Ports:
//   clk    - system clock; all logic runs on the rising edge
//   rst    - asynchronous, active-low reset
//   flush  - (optional) synchronous flush, active-high
//   din    - pattern to enqueue
//   wr_en  - enqueue din on this edge, ignored while full
//   full   - FIFO holds DEPTH entries
//   empty  - FIFO holds no entries (the pattern being driven is not counted)
//   out    - registered pattern being driven
//   busy   - sequencer is holding a pattern or in the gap after one
module output_sequencer #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned POINTER_WIDTH = 3,
  parameter int unsigned HOLD_CNT_MAX  = 62500,
  parameter int unsigned GAP_CNT_MAX   = 200
) (
  input  logic             clk,
  input  logic             rst,
`ifdef OUTPUT_SEQUENCER_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  // The counter covers the larger of the two intervals, and is never narrower than one bit.
  localparam int unsigned HoldMin = (HOLD_CNT_MAX > 2) ? HOLD_CNT_MAX : 2;
  localparam int unsigned GapMin  = (GAP_CNT_MAX > 2) ? GAP_CNT_MAX : 2;
  localparam int unsigned CntMax  = (HoldMin > GapMin) ? HoldMin : GapMin;
  localparam int unsigned CntW    = $clog2(CntMax);

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CNT_MAX - 1);
  // GAP_CNT_MAX == 0 never enters the gap state, so this value is then unused.
  localparam logic [CntW-1:0] GapLast  = CntW'((GAP_CNT_MAX > 0) ? GAP_CNT_MAX - 1 : 0);

  localparam logic [POINTER_WIDTH:0]   DepthCnt = (POINTER_WIDTH + 1)'(DEPTH);
  localparam logic [POINTER_WIDTH-1:0] PtrLast  = POINTER_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StGap
  } state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]         out_q, out_d;

  logic [WIDTH-1:0]         mem_q [DEPTH];
  logic [POINTER_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [POINTER_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [POINTER_WIDTH:0]   count_q, count_d;

  logic                     flush_req;
  logic                     push;
  logic                     pop;
  logic [WIDTH-1:0]         head;

`ifdef OUTPUT_SEQUENCER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Full and empty are decoded from the registered count. A pop on the same edge therefore
  // does not free space for a write while the FIFO is full.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = wr_en && !full && !flush_req;

  assign out  = out_q;
  assign busy = (state_q != StIdle);

  // ---------------------------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        out_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          out_d   = head;
          cnt_d   = '0;
          state_d = StHold;
        end
      end

      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d = '0;
          if (GAP_CNT_MAX > 0) begin
            out_d   = '0;
            state_d = StGap;
          end else if (!empty) begin
            // Without a gap the next pattern follows directly.
            pop   = 1'b1;
            out_d = head;
          end else begin
            out_d   = '0;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StGap: begin
        out_d = '0;
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            out_d   = head;
            state_d = StHold;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        out_d   = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    if (flush_req) begin
      state_d = StIdle;
      cnt_d   = '0;
      out_d   = '0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + POINTER_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + POINTER_WIDTH'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (POINTER_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (POINTER_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase

    if (flush_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset. An entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: tb/tb_output_sequencer.sv
// Randomised and directed bench for output_sequencer. It drives three instances from shared
// stimulus:
//   [0] HOLD=4,  GAP=2
//   [1] HOLD=4,  GAP=0
//   [2] HOLD=16, GAP=2
// All instances use WIDTH=4 and DEPTH=8. Each instance is compared against an event-timeline
// model that holds a list of queued patterns and tracks when the next pop is allowed.
module tb_output_sequencer;

  localparam int unsigned Depth = 8;
  localparam int          NDut  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = '0;
  logic       wr_en = 1'b0;
`ifdef OUTPUT_SEQUENCER_FLUSH_EN
  logic       flush = 1'b0;
`endif

  logic [3:0] out_w   [NDut];
  logic       busy_w  [NDut];
  logic       empty_w [NDut];
  logic       full_w  [NDut];

  always #5 clk = ~clk;

  output_sequencer #(
    .WIDTH(4), .DEPTH(8), .POINTER_WIDTH(3), .HOLD_CNT_MAX(4), .GAP_CNT_MAX(2)
  ) dut_g (
    .clk(clk), .rst(rst),
`ifdef OUTPUT_SEQUENCER_FLUSH_EN
    .flush(flush),
`endif
    .din(din), .wr_en(wr_en), .full(full_w[0]), .empty(empty_w[0]), .out(out_w[0]),
    .busy(busy_w[0])
  );

  output_sequencer #(
    .WIDTH(4), .DEPTH(8), .POINTER_WIDTH(3), .HOLD_CNT_MAX(4), .GAP_CNT_MAX(0)
  ) dut_n (
    .clk(clk), .rst(rst),
`ifdef OUTPUT_SEQUENCER_FLUSH_EN
    .flush(flush),
`endif
    .din(din), .wr_en(wr_en), .full(full_w[1]), .empty(empty_w[1]), .out(out_w[1]),
    .busy(busy_w[1])
  );

  output_sequencer #(
    .WIDTH(4), .DEPTH(8), .POINTER_WIDTH(3), .HOLD_CNT_MAX(16), .GAP_CNT_MAX(2)
  ) dut_o (
    .clk(clk), .rst(rst),
`ifdef OUTPUT_SEQUENCER_FLUSH_EN
    .flush(flush),
`endif
    .din(din), .wr_en(wr_en), .full(full_w[2]), .empty(empty_w[2]), .out(out_w[2]),
    .busy(busy_w[2])
  );

  // Reference model state.
  int         hold_c   [NDut];
  int         gap_c    [NDut];
  logic [3:0] mq       [NDut][Depth];
  int         mcnt     [NDut];
  bit         have_ev  [NDut];
  int         ev_start [NDut];
  logic [3:0] ev_pat   [NDut];
  int         free_at  [NDut];
  int         k;

  int         n_vec;
  int         n_err;
  int         ev_cnt_o;
  logic [3:0] prev_o;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < NDut; m++) begin
      mcnt[m]    = 0;
      have_ev[m] = 1'b0;
      free_at[m] = 0;
    end
  endtask

  // One clock edge of model m. The inputs are the values presented before the edge.
  task automatic model_step(input int m, input bit wr, input logic [3:0] d, input bit fl);
    bit acc;
    if (fl) begin
      mcnt[m]    = 0;
      have_ev[m] = 1'b0;
      free_at[m] = k;
      return;
    end
    acc = wr && (mcnt[m] < Depth);
    if (k >= free_at[m] && mcnt[m] > 0) begin
      ev_pat[m] = mq[m][0];
      for (int j = 0; j < mcnt[m] - 1; j++) mq[m][j] = mq[m][j+1];
      mcnt[m]--;
      have_ev[m]  = 1'b1;
      ev_start[m] = k;
      free_at[m]  = k + hold_c[m] + gap_c[m];
    end
    if (acc) begin
      mq[m][mcnt[m]] = d;
      mcnt[m]++;
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < NDut; m++) begin
      int         el;
      logic [3:0] e_out;
      bit         e_busy;
      el     = k - ev_start[m];
      e_out  = (have_ev[m] && el < hold_c[m]) ? ev_pat[m] : 4'h0;
      e_busy = have_ev[m] && (el < hold_c[m] + gap_c[m]);
      check_eq($sformatf("out[%0d]", m), 32'(out_w[m]), 32'(e_out));
      check_eq($sformatf("busy[%0d]", m), 32'(busy_w[m]), 32'(e_busy));
      check_eq($sformatf("empty[%0d]", m), 32'(empty_w[m]), 32'(mcnt[m] == 0));
      check_eq($sformatf("full[%0d]", m), 32'(full_w[m]), 32'(mcnt[m] == Depth));
    end
  endtask

  task automatic cycle(input bit wr, input logic [3:0] d, input bit fl);
    wr_en = wr;
    din   = d;
`ifdef OUTPUT_SEQUENCER_FLUSH_EN
    flush = fl;
`endif
    @(posedge clk);
    for (int m = 0; m < NDut; m++) model_step(m, wr, d, fl);
    #1;
    compare_all();
    if (out_w[2] != 4'h0 && prev_o == 4'h0) ev_cnt_o++;
    prev_o = out_w[2];
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0);
  endtask

  // Assert reset between edges and check that it acts immediately.
  task automatic reset_mid();
    #2 rst = 1'b0;
    #1;
    for (int m = 0; m < NDut; m++) begin
      check_eq($sformatf("rst_out[%0d]", m), 32'(out_w[m]), 32'h0);
      check_eq($sformatf("rst_busy[%0d]", m), 32'(busy_w[m]), 32'h0);
      check_eq($sformatf("rst_empty[%0d]", m), 32'(empty_w[m]), 32'h1);
      check_eq($sformatf("rst_full[%0d]", m), 32'(full_w[m]), 32'h0);
    end
    model_reset();
    prev_o = 4'h0;
    #2 rst = 1'b1;
  endtask

  initial begin
    hold_c = '{4, 4, 16};
    gap_c  = '{2, 0, 2};
    n_vec = 0;
    n_err = 0;
    k = 0;
    ev_cnt_o = 0;
    prev_o = 4'h0;
    model_reset();

    // Reset is asserted at time zero.
    #3;
    for (int m = 0; m < NDut; m++) begin
      check_eq($sformatf("init_out[%0d]", m), 32'(out_w[m]), 32'h0);
      check_eq($sformatf("init_empty[%0d]", m), 32'(empty_w[m]), 32'h1);
      check_eq($sformatf("init_busy[%0d]", m), 32'(busy_w[m]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Single event.
    cycle(1'b1, 4'h1, 1'b0);
    idle(24);

    // Back-to-back A, A, 5.
    cycle(1'b1, 4'hA, 1'b0);
    cycle(1'b1, 4'hA, 1'b0);
    cycle(1'b1, 4'h5, 1'b0);
    idle(60);

    // Two writes, which exercises the no-gap instance.
    cycle(1'b1, 4'h3, 1'b0);
    cycle(1'b1, 4'hC, 1'b0);
    idle(40);

    // Overflow: one pattern goes into HOLD, then a burst of ten distinct writes.
    ev_cnt_o = 0;
    prev_o = out_w[2];
    cycle(1'b1, 4'h1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i + 2), 1'b0);
    check_eq("ovf_full", 32'(full_w[2]), 32'h1);
    idle(200);
    check_eq("ovf_events", 32'(ev_cnt_o), 32'd9);

    // Reset while a pattern is in HOLD.
    cycle(1'b1, 4'h7, 1'b0);
    idle(2);
    reset_mid();
    idle(10);

`ifdef OUTPUT_SEQUENCER_FLUSH_EN
    // Five entries are queued behind the driven one. Flush together with a write.
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 1), 1'b0);
    cycle(1'b1, 4'hF, 1'b1);
    check_eq("flush_out", 32'(out_w[2]), 32'h0);
    check_eq("flush_empty", 32'(empty_w[2]), 32'h1);
    check_eq("flush_busy", 32'(busy_w[2]), 32'h0);
    idle(30);
`endif

    // Randomised traffic, including zero patterns.
    for (int i = 0; i < 800; i++) begin
      bit         wr;
      bit         fl;
      logic [3:0] d;
      wr = ($urandom_range(0, 2) == 0);
      d  = 4'($urandom_range(0, 15));
      fl = 1'b0;
`ifdef OUTPUT_SEQUENCER_FLUSH_EN
      fl = ($urandom_range(0, 59) == 0);
`endif
      cycle(wr, d, fl);
      if ($urandom_range(0, 199) == 0) reset_mid();
    end
    idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_sequencer.md
Name: output_sequencer

Overview:
- Transmit-side counterpart of the button input chain: software or core logic pushes output patterns into an internal FIFO.
- The block drives each pattern on `out` for exactly HOLD_CNT_MAX cycles, then drives zero for GAP_CNT_MAX cycles.
- The gap makes consecutive identical events visibly distinct.
- Used for LED and user-visible output events fed from MMIO or an event source.

Parameters:
- WIDTH, 1, width of each pattern and of `out`.
- DEPTH, 8, FIFO entries.
- POINTER_WIDTH, 3, log2(DEPTH).
- HOLD_CNT_MAX, 62500, cycles each pattern is driven; must be ≥1.
- GAP_CNT_MAX, 200, cycles of zero output between patterns; 0 means no gap.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- din  input  WIDTH  pattern to enqueue.
- wr_en  input  1  enqueue din on this edge if full=0.
- full  output  WIDTH-independent 1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries; the pattern being driven does not count.
- out  output  WIDTH  registered driven pattern.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - out=0, busy=0, empty=1, full=0.
  - FIFO pointers and count=0; hold/gap counter=0; state=IDLE.
  - Deassertion is synchronous-safe: no activity until the first edge with rst=1.
- FIFO:
  - First-word-fall-through; head is valid whenever empty=0.
  - Pointers wrap modulo DEPTH.
  - Count width is POINTER_WIDTH+1; full when count==DEPTH.
  - wr_en with full=1: ignored, no state change, data dropped.
- Push and pop on the same edge:
  - Allowed when full=0; count unchanged.
  - When full=1 the write is rejected even if a pop occurs on that edge; full is evaluated from the registered count.
- FSM states: IDLE, HOLD, GAP.
  - IDLE:
    - out=0.
    - If empty=0: pop head, out<=head, counter<=0, go to HOLD.
  - HOLD:
    - out holds the pattern; counter increments each cycle.
    - When counter==HOLD_CNT_MAX-1, on that edge:
      - If GAP_CNT_MAX>0: out<=0, counter<=0, go to GAP.
      - Else if empty=0: pop, out<=head, counter<=0, stay in HOLD.
      - Else: out<=0, go to IDLE.
  - GAP:
    - out=0; counter increments each cycle.
    - When counter==GAP_CNT_MAX-1:
      - If empty=0: pop, out<=head, counter<=0, go to HOLD.
      - Else: go to IDLE.
- busy=1 in HOLD and GAP.
- Latency:
  - write at edge N into an empty FIFO with the FSM in IDLE → empty=0 after N.
  - Pop at N+1, out=din valid after edge N+1.
  - out stays valid for exactly HOLD_CNT_MAX cycles.
- Back-to-back: with FIFO non-empty, out has no extra idle cycle between gap end and the next pattern. Period is exactly HOLD_CNT_MAX+GAP_CNT_MAX cycles.
- Pattern value 0 is legal: it is held for HOLD_CNT_MAX cycles like any other pattern and still counts as an event.
- Counter width: $clog2(max(HOLD_CNT_MAX,GAP_CNT_MAX,2)). No overflow is possible because the counter is reset at each terminal count.

Optional Feature:
- Macro: OUTPUT_SEQUENCER_FLUSH_EN
- With the macro defined:
  - Adds input port `flush` (1 bit, synchronous, active-high).
  - On an edge with flush=1: FIFO count and pointers <=0, state<=IDLE, out<=0, counter<=0.
  - flush overrides a simultaneous wr_en; that write is discarded.
- Without the macro: no `flush` port; the FIFO drains only through the FSM.

Test Plan:
- Reset mid-HOLD: drive rst=0 asynchronously between edges → out=0, busy=0, empty=1 immediately, before the next edge.
- Single event, HOLD_CNT_MAX=4, GAP_CNT_MAX=2: write 1'b1 at edge N → out=1 from edge N+1 through N+5, 0 during the gap, then IDLE with busy=0 from N+7.
- Back-to-back, WIDTH=4: write 4'hA, 4'hA, 4'h5 on consecutive edges → out sequence A×4, 0×2, A×4, 0×2, 5×4, then 0; no extra idle cycles.
- Overflow, DEPTH=8: while the first pattern is in HOLD, write 10 distinct values.
  - full=1 after 8 are queued; extras are dropped.
  - Exactly 9 patterns appear on out: 1 driven plus 8 queued.
- GAP_CNT_MAX=0: two writes → out shows pattern 1 for HOLD_CNT_MAX cycles, then pattern 2 immediately on the next cycle, then 0.
- With OUTPUT_SEQUENCER_FLUSH_EN: queue 5 entries, assert flush during HOLD together with wr_en → next cycle out=0, empty=1, busy=0; no further patterns appear.
